// File: rtl/cw305_reg_opbank.sv
// CW305 operand/result register bank: host byte access, core word access,
// and a start/busy/done control FSM with latency counter and timeout abort.
module cw305_reg_opbank #(
    parameter int pREG_ADDR_W   = 8,
    parameter int pBYTECNT_SIZE = 8,
    parameter int pOP_WIDTH     = 256,
    parameter int pNUM_IN       = 3,
    parameter int pNUM_OUT      = 2,
    parameter int pWADDR_W      = 3
) (
    input  logic                         crypto_clk,
    input  logic                         reset_n,
    input  logic [pREG_ADDR_W-1:0]       reg_address,
    input  logic [pBYTECNT_SIZE-1:0]     reg_bytecnt,
    input  logic [7:0]                   write_data,
    output logic [7:0]                   read_data,
    input  logic                         reg_read,
    input  logic                         reg_write,
    input  logic                         reg_addrvalid,
    input  logic                         exttrigger_in,
    input  logic [pNUM_IN*pWADDR_W-1:0]  I_in_addr,
    output logic [pNUM_IN*32-1:0]        O_in_word,
    input  logic [pNUM_OUT-1:0]          I_out_wren,
    input  logic [pNUM_OUT*pWADDR_W-1:0] I_out_addr,
    input  logic [pNUM_OUT*32-1:0]       I_out_word,
    input  logic                         I_done,
    output logic                         O_start,
    output logic                         O_abort,
    output logic                         O_busy
);
    localparam int BIDX_W = $clog2(pOP_WIDTH / 8);
    localparam logic [pBYTECNT_SIZE-1:0] OP_BYTES   = pBYTECNT_SIZE'(pOP_WIDTH / 8);
    localparam logic [pBYTECNT_SIZE-1:0] WORD_BYTES = pBYTECNT_SIZE'(4);
    localparam logic [pREG_ADDR_W-1:0] ADDR_CTRL    = 'h00;
    localparam logic [pREG_ADDR_W-1:0] ADDR_GO      = 'h01;
    localparam logic [pREG_ADDR_W-1:0] ADDR_CYCLES  = 'h02;
    localparam logic [pREG_ADDR_W-1:0] ADDR_TIMEOUT = 'h03;
    localparam logic [pREG_ADDR_W-1:0] ADDR_OP      = 'h10;
    localparam logic [pREG_ADDR_W-1:0] ADDR_RES     = 'h20;

    typedef enum logic [1:0] {S_IDLE, S_START, S_BUSY, S_DONE} state_t;

    state_t                 state_q, state_d;
    logic [pOP_WIDTH-1:0]   op_q  [pNUM_IN];
    logic [pOP_WIDTH-1:0]   op_d  [pNUM_IN];
    logic [pOP_WIDTH-1:0]   res_q [pNUM_OUT];
    logic [pOP_WIDTH-1:0]   res_d [pNUM_OUT];
    logic [31:0]            cycles_q, cycles_d, timeout_q, timeout_d;
    logic                   trig_en_q, trig_en_d, err_q, err_d;
    logic                   done_q, done_d, tmo_q, tmo_d, trig_prev_q;
    logic [7:0]             rd_q, rd_d;
    logic [pNUM_IN*32-1:0]  in_word_q, in_word_d;

    logic                   host_wr, host_rd, go_wr, trig_rise, start_req;
    logic                   byte_ok, word_byte_ok, op_addr, lock_wr, timeout_hit;
    logic [BIDX_W-1:0]      byte_idx;
    logic [1:0]             wsel;
    logic [7:0]             status;

    assign host_wr      = reg_write & reg_addrvalid;
    assign host_rd      = reg_read & reg_addrvalid;
    assign byte_idx     = reg_bytecnt[BIDX_W-1:0];
    assign wsel         = reg_bytecnt[1:0];
    assign byte_ok      = reg_bytecnt < OP_BYTES;
    assign word_byte_ok = reg_bytecnt < WORD_BYTES;
    assign op_addr      = (reg_address >= ADDR_OP) &&
                          (reg_address < ADDR_OP + pREG_ADDR_W'(pNUM_IN));
    assign go_wr        = host_wr && (reg_address == ADDR_GO);
    assign trig_rise    = trig_en_q & exttrigger_in & ~trig_prev_q;
    assign start_req    = go_wr | trig_rise;
    assign timeout_hit  = (timeout_q != 32'd0) && (cycles_q == timeout_q - 32'd1);
    // Writes that would disturb a running operation are dropped and flagged.
    assign lock_wr      = host_wr && O_busy &&
                          (reg_address == ADDR_CTRL || reg_address == ADDR_GO ||
                           reg_address == ADDR_TIMEOUT || op_addr);
    assign status       = {4'b0, err_q, tmo_q, done_q, O_busy};

    always_ff @(posedge crypto_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            // NOTE: register arrays are reset too, so the host reads 0 after reset.
            for (int i = 0; i < pNUM_IN; i++)  op_q[i]  <= '0;
            for (int j = 0; j < pNUM_OUT; j++) res_q[j] <= '0;
            cycles_q    <= '0;
            timeout_q   <= '0;
            trig_en_q   <= 1'b0;
            err_q       <= 1'b0;
            done_q      <= 1'b0;
            tmo_q       <= 1'b0;
            trig_prev_q <= 1'b0;
            rd_q        <= '0;
            in_word_q   <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            res_q       <= res_d;
            cycles_q    <= cycles_d;
            timeout_q   <= timeout_d;
            trig_en_q   <= trig_en_d;
            err_q       <= err_d;
            done_q      <= done_d;
            tmo_q       <= tmo_d;
            trig_prev_q <= exttrigger_in;
            rd_q        <= rd_d;
            in_word_q   <= in_word_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start_req) state_d = S_START;
            S_START: state_d = S_BUSY;
            S_BUSY:  if (I_done) state_d = S_DONE;
                     else if (timeout_hit) state_d = S_IDLE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        O_start = (state_q == S_START);
        O_busy  = (state_q == S_START) || (state_q == S_BUSY);
        O_abort = (state_q == S_BUSY) && !I_done && timeout_hit;
    end

    always_comb begin
        // NOTE: every target gets a default first so no latches are inferred.
        op_d      = op_q;
        res_d     = res_q;
        cycles_d  = cycles_q;
        timeout_d = timeout_q;
        trig_en_d = trig_en_q;
        err_d     = err_q;
        done_d    = done_q;
        tmo_d     = tmo_q;
        if (host_wr && !O_busy) begin
            if (reg_address == ADDR_CTRL && reg_bytecnt == '0) begin
                trig_en_d = write_data[0];
                if (write_data[1]) err_d = 1'b0;
            end
            if (reg_address == ADDR_TIMEOUT && word_byte_ok)
                timeout_d[{wsel, 3'b000} +: 8] = write_data;
            for (int i = 0; i < pNUM_IN; i++)
                if (reg_address == ADDR_OP + pREG_ADDR_W'(i) && byte_ok)
                    op_d[i][{byte_idx, 3'b000} +: 8] = write_data;
        end
        if (lock_wr) err_d = 1'b1;
        for (int j = 0; j < pNUM_OUT; j++)
            if (I_out_wren[j])
                res_d[j][{I_out_addr[j*pWADDR_W +: pWADDR_W], 5'b00000} +: 32] =
                    I_out_word[j*32 +: 32];
        case (state_q)
            S_START: begin
                cycles_d = '0;
                done_d   = 1'b0;
                tmo_d    = 1'b0;
            end
            S_BUSY: begin
                if (cycles_q != '1) cycles_d = cycles_q + 32'd1;
                if (!I_done && timeout_hit) tmo_d = 1'b1;
            end
            S_DONE:  done_d = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        rd_d = '0;
        if (host_rd) begin
            if (reg_address == ADDR_CTRL && reg_bytecnt == '0) rd_d = {7'b0, trig_en_q};
            if (reg_address == ADDR_GO && reg_bytecnt == '0)   rd_d = status;
            if (reg_address == ADDR_CYCLES && word_byte_ok)    rd_d = cycles_q[{wsel, 3'b000} +: 8];
            if (reg_address == ADDR_TIMEOUT && word_byte_ok)   rd_d = timeout_q[{wsel, 3'b000} +: 8];
            for (int i = 0; i < pNUM_IN; i++)
                if (reg_address == ADDR_OP + pREG_ADDR_W'(i) && byte_ok)
                    rd_d = op_q[i][{byte_idx, 3'b000} +: 8];
            for (int j = 0; j < pNUM_OUT; j++)
                if (reg_address == ADDR_RES + pREG_ADDR_W'(j) && byte_ok)
                    rd_d = res_q[j][{byte_idx, 3'b000} +: 8];
        end
    end

    always_comb begin
        in_word_d = '0;
        for (int i = 0; i < pNUM_IN; i++)
            in_word_d[i*32 +: 32] = op_q[i][{I_in_addr[i*pWADDR_W +: pWADDR_W], 5'b00000} +: 32];
    end

    assign read_data = rd_q;
    assign O_in_word = in_word_q;

endmodule

// File: tb/tb_cw305_reg_opbank.sv
// Directed bench for cw305_reg_opbank: host map, core word ports, control FSM.
module tb_cw305_reg_opbank;
    logic        crypto_clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [7:0]  reg_address = '0, reg_bytecnt = '0, write_data = '0;
    logic [7:0]  read_data;
    logic        reg_read = 1'b0, reg_write = 1'b0, reg_addrvalid = 1'b0;
    logic        exttrigger_in = 1'b0;
    logic [8:0]  I_in_addr = '0;
    logic [95:0] O_in_word;
    logic [1:0]  I_out_wren = '0;
    logic [5:0]  I_out_addr = '0;
    logic [63:0] I_out_word = '0;
    logic        I_done = 1'b0;
    logic        O_start, O_abort, O_busy;

    int total = 0;
    int bad = 0;
    int start_cnt = 0;
    int abort_cnt = 0;

    cw305_reg_opbank dut (
        .crypto_clk(crypto_clk), .reset_n(reset_n),
        .reg_address(reg_address), .reg_bytecnt(reg_bytecnt),
        .write_data(write_data), .read_data(read_data),
        .reg_read(reg_read), .reg_write(reg_write), .reg_addrvalid(reg_addrvalid),
        .exttrigger_in(exttrigger_in),
        .I_in_addr(I_in_addr), .O_in_word(O_in_word),
        .I_out_wren(I_out_wren), .I_out_addr(I_out_addr), .I_out_word(I_out_word),
        .I_done(I_done), .O_start(O_start), .O_abort(O_abort), .O_busy(O_busy)
    );

    always #5 crypto_clk = ~crypto_clk;

    always @(negedge crypto_clk) begin
        if (O_start) start_cnt++;
        if (O_abort) abort_cnt++;
    end

    task automatic tick();
        @(posedge crypto_clk);
        #1;
    endtask

    task automatic host_write(input logic [7:0] a, input logic [7:0] b, input logic [7:0] d);
        reg_address = a; reg_bytecnt = b; write_data = d;
        reg_write = 1'b1; reg_addrvalid = 1'b1;
        tick();
        reg_write = 1'b0; reg_addrvalid = 1'b0;
    endtask

    task automatic host_read(input logic [7:0] a, input logic [7:0] b, output logic [7:0] d);
        reg_address = a; reg_bytecnt = b;
        reg_read = 1'b1; reg_addrvalid = 1'b1;
        tick();
        d = read_data;
        reg_read = 1'b0; reg_addrvalid = 1'b0;
    endtask

    task automatic read32(input logic [7:0] a, output logic [31:0] w);
        logic [7:0] d;
        for (int b = 0; b < 4; b++) begin
            host_read(a, 8'(b), d);
            w[b*8 +: 8] = d;
        end
    endtask

    task automatic test_reset();
        logic [7:0]  d;
        logic [31:0] w;
        if ({O_start, O_abort, O_busy} !== 3'b000) begin
            bad++; $display("FAIL reset_ctl got=%b exp=000", {O_start, O_abort, O_busy});
        end
        total++;
        if (read_data !== 8'h00) begin bad++; $display("FAIL reset_rd got=%h exp=00", read_data); end
        total++;
        if (O_in_word !== 96'h0) begin bad++; $display("FAIL reset_inword got=%h exp=0", O_in_word); end
        total++;
        host_read(8'h01, 8'd0, d);
        if (d !== 8'h00) begin bad++; $display("FAIL reset_status got=%h exp=00", d); end
        total++;
        host_read(8'h00, 8'd0, d);
        if (d !== 8'h00) begin bad++; $display("FAIL reset_ctrl got=%h exp=00", d); end
        total++;
        read32(8'h03, w);
        if (w !== 32'h0) begin bad++; $display("FAIL reset_timeout got=%h exp=0", w); end
        total++;
        tick();
        if (read_data !== 8'h00) begin bad++; $display("FAIL rd_idle got=%h exp=00", read_data); end
        total++;
    endtask

    task automatic test_operand();
        logic [7:0] d;
        for (int b = 0; b < 32; b++) host_write(8'h10, 8'(b), 8'(b));
        host_write(8'h10, 8'd32, 8'hAA);
        host_write(8'h11, 8'd4, 8'h5A);
        I_in_addr = {3'd0, 3'd1, 3'd1};
        tick();
        if (O_in_word[31:0] !== 32'h07060504) begin
            bad++; $display("FAIL op0_w1 got=%h exp=07060504", O_in_word[31:0]);
        end
        total++;
        if (O_in_word[63:32] !== 32'h0000005A) begin
            bad++; $display("FAIL op1_w1 got=%h exp=0000005a", O_in_word[63:32]);
        end
        total++;
        I_in_addr = {3'd0, 3'd0, 3'd7};
        tick();
        if (O_in_word[31:0] !== 32'h1F1E1D1C) begin
            bad++; $display("FAIL op0_w7 got=%h exp=1f1e1d1c", O_in_word[31:0]);
        end
        total++;
        host_read(8'h10, 8'd5, d);
        if (d !== 8'h05) begin bad++; $display("FAIL op0_b5 got=%h exp=05", d); end
        total++;
        host_read(8'h10, 8'd32, d);
        if (d !== 8'h00) begin bad++; $display("FAIL op0_b32 got=%h exp=00", d); end
        total++;
        host_read(8'h7F, 8'd0, d);
        if (d !== 8'h00) begin bad++; $display("FAIL unmapped got=%h exp=00", d); end
        total++;
        I_in_addr = '0;
    endtask

    task automatic test_result();
        logic [31:0] w;
        logic [7:0]  d;
        I_out_wren = 2'b10; I_out_addr = {3'd2, 3'd0}; I_out_word = {32'hDEADBEEF, 32'h0};
        tick();
        I_out_wren = '0;
        read32(8'h21, w);
        if (w !== 32'h0) begin bad++; $display("FAIL res1_w0 got=%h exp=0", w); end
        total++;
        for (int b = 0; b < 4; b++) begin
            host_read(8'h21, 8'(8 + b), d);
            w[b*8 +: 8] = d;
        end
        if (w !== 32'hDEADBEEF) begin bad++; $display("FAIL res1_w2 got=%h exp=deadbeef", w); end
        total++;
        reg_address = 8'h20; reg_bytecnt = 8'd0; reg_read = 1'b1; reg_addrvalid = 1'b1;
        I_out_wren = 2'b01; I_out_addr = '0; I_out_word = {32'h0, 32'h11223344};
        tick();
        d = read_data;
        reg_read = 1'b0; reg_addrvalid = 1'b0; I_out_wren = '0;
        if (d !== 8'h00) begin bad++; $display("FAIL res_same_cycle got=%h exp=00", d); end
        total++;
        host_read(8'h20, 8'd0, d);
        if (d !== 8'h44) begin bad++; $display("FAIL res0_b0 got=%h exp=44", d); end
        total++;
    endtask

    task automatic test_go_done();
        logic [7:0]  d;
        logic [31:0] w;
        int s0;
        I_done = 1'b1;
        tick();
        I_done = 1'b0;
        if (O_busy !== 1'b0) begin bad++; $display("FAIL done_idle got=%b exp=0", O_busy); end
        total++;
        s0 = start_cnt;
        host_write(8'h01, 8'd0, 8'h01);
        if (O_start !== 1'b1 || O_busy !== 1'b1) begin
            bad++; $display("FAIL go_start got=%b%b exp=11", O_start, O_busy);
        end
        total++;
        tick();
        if (O_start !== 1'b0) begin bad++; $display("FAIL go_pulse got=%b exp=0", O_start); end
        total++;
        repeat (9) tick();
        I_done = 1'b1;
        tick();
        I_done = 1'b0;
        tick(); tick();
        host_read(8'h01, 8'd0, d);
        if (d !== 8'h02) begin bad++; $display("FAIL go_status got=%h exp=02", d); end
        total++;
        read32(8'h02, w);
        if (w !== 32'd10) begin bad++; $display("FAIL go_cycles got=%0d exp=10", w); end
        total++;
        if (start_cnt - s0 !== 1) begin bad++; $display("FAIL go_starts got=%0d exp=1", start_cnt - s0); end
        total++;
    endtask

    task automatic test_timeout();
        logic [7:0] d;
        int a0;
        a0 = abort_cnt;
        host_write(8'h03, 8'd0, 8'd5);
        host_write(8'h01, 8'd0, 8'h01);
        repeat (4) tick();
        if (O_abort !== 1'b0) begin bad++; $display("FAIL tmo_early got=%b exp=0", O_abort); end
        total++;
        tick();
        if (O_abort !== 1'b1) begin bad++; $display("FAIL tmo_abort got=%b exp=1", O_abort); end
        total++;
        tick();
        if (O_abort !== 1'b0 || O_busy !== 1'b0) begin
            bad++; $display("FAIL tmo_idle got=%b%b exp=00", O_abort, O_busy);
        end
        total++;
        host_read(8'h01, 8'd0, d);
        if (d !== 8'h04) begin bad++; $display("FAIL tmo_status got=%h exp=04", d); end
        total++;
        if (abort_cnt - a0 !== 1) begin bad++; $display("FAIL tmo_count got=%0d exp=1", abort_cnt - a0); end
        total++;
        host_write(8'h03, 8'd0, 8'd0);
    endtask

    task automatic test_lock();
        logic [7:0] d;
        int s0;
        s0 = start_cnt;
        host_write(8'h01, 8'd0, 8'h01);
        host_write(8'h10, 8'd0, 8'hFF);
        host_write(8'h01, 8'd0, 8'h01);
        host_write(8'h00, 8'd0, 8'h02);
        I_done = 1'b1;
        tick();
        I_done = 1'b0;
        tick(); tick();
        host_read(8'h10, 8'd0, d);
        if (d !== 8'h00) begin bad++; $display("FAIL lock_op got=%h exp=00", d); end
        total++;
        host_read(8'h01, 8'd0, d);
        if (d !== 8'h0A) begin bad++; $display("FAIL lock_err got=%h exp=0a", d); end
        total++;
        if (start_cnt - s0 !== 1) begin bad++; $display("FAIL lock_starts got=%0d exp=1", start_cnt - s0); end
        total++;
        host_write(8'h00, 8'd0, 8'h02);
        host_read(8'h01, 8'd0, d);
        if (d !== 8'h02) begin bad++; $display("FAIL clr_err got=%h exp=02", d); end
        total++;
    endtask

    task automatic test_trigger();
        int s0;
        s0 = start_cnt;
        host_write(8'h00, 8'd0, 8'h01);
        exttrigger_in = 1'b1;
        host_write(8'h01, 8'd0, 8'h01);
        repeat (3) tick();
        I_done = 1'b1;
        tick();
        I_done = 1'b0;
        repeat (3) tick();
        if (start_cnt - s0 !== 1) begin bad++; $display("FAIL trig_same got=%0d exp=1", start_cnt - s0); end
        total++;
        exttrigger_in = 1'b0;
        tick();
        exttrigger_in = 1'b1;
        tick(); tick();
        if (O_busy !== 1'b1) begin bad++; $display("FAIL trig_busy got=%b exp=1", O_busy); end
        total++;
        I_done = 1'b1;
        tick();
        I_done = 1'b0;
        tick(); tick();
        if (start_cnt - s0 !== 2) begin bad++; $display("FAIL trig_edge got=%0d exp=2", start_cnt - s0); end
        total++;
        exttrigger_in = 1'b0;
    endtask

    task automatic test_reset_mid_busy();
        logic [7:0] d;
        host_write(8'h01, 8'd0, 8'h01);
        tick(); tick();
        if (O_busy !== 1'b1) begin bad++; $display("FAIL rst_pre got=%b exp=1", O_busy); end
        total++;
        I_in_addr = {3'd0, 3'd0, 3'd1};
        #2 reset_n = 1'b0;
        #1;
        if ({O_start, O_abort, O_busy} !== 3'b000 || read_data !== 8'h00 || O_in_word !== 96'h0) begin
            bad++; $display("FAIL rst_async got=%b_%h_%h exp=000_00_0",
                            {O_start, O_abort, O_busy}, read_data, O_in_word);
        end
        total++;
        tick();
        reset_n = 1'b1;
        I_in_addr = '0;
        tick();
        host_read(8'h10, 8'd5, d);
        if (d !== 8'h00) begin bad++; $display("FAIL rst_op got=%h exp=00", d); end
        total++;
        host_read(8'h00, 8'd0, d);
        if (d !== 8'h00) begin bad++; $display("FAIL rst_ctrl got=%h exp=00", d); end
        total++;
        host_read(8'h01, 8'd0, d);
        if (d !== 8'h00) begin bad++; $display("FAIL rst_status got=%h exp=00", d); end
        total++;
    endtask

    initial begin
        #12 reset_n = 1'b1;
        tick();
        test_reset();
        test_operand();
        test_result();
        test_go_done();
        test_timeout();
        test_lock();
        test_trigger();
        test_reset_mid_busy();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
